reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Consumer end of the instruction queue's valid/ready dispatch interface.
- Accepts one instruction_element_t per cycle into one of DEPTH entries.
- Watches the common data bus (CDB) and captures any operand still tagged busy (CB=1) when its producing ROB tag is broadcast.
- Issues the oldest entry whose operands are both resolved to the functional unit through a second valid/ready interface.

Parameters:
- WIDTH, $bits(instruction_element_t), width of one stored entry.
- DEPTH, 4, number of entries (2..8).

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- flush  input  1  synchronous squash of all entries (branch mispredict).
- vld_i  input  1  dispatch valid from the instruction queue.
- rdy_i  output  1  an entry is free to accept.
- instruction_i  input  WIDTH  dispatched instruction. When CB1/CB2=1, val1/val2[ROB_IDX_LEN-1:0] holds the producer ROB tag.
- cdb_vld_i  input  1  CDB broadcast valid.
- cdb_tag_i  input  ROB_IDX_LEN  ROB index of the broadcast result.
- cdb_data_i  input  32  broadcast result value.
- vld_o  output  1  an entry is ready to issue.
- rdy_o  input  1  functional unit accepts.
- instruction_o  output  WIDTH  issued instruction; CB1=CB2=0 guaranteed.

Behaviour:
- Reset and clock: one clock (clk). rst is synchronous and active-high.
- Effect of rst: clears all entry valid bits and age state.
- Outputs while rst or flush is high: rdy_i=0, vld_o=0.
- instruction_o is don't-care when vld_o=0.
- Flush: same effect as rst on the next edge. It takes priority over accept, issue and CDB capture in that cycle.
- Accept:
  - rdy_i=1 iff at least one entry is invalid, judged on registered state only. A same-cycle issue does not free a slot for a same-cycle accept.
  - On vld_i&&rdy_i, the lowest-index free entry is written with instruction_i. It becomes valid next cycle and is marked youngest.
- CDB capture, each cycle, per valid entry and per operand n:
  - If cdb_vld_i && CBn==1 && valn[ROB_IDX_LEN-1:0]==cdb_tag_i, then next cycle valn[31:0]=cdb_data_i and CBn=0.
  - Both operands of one entry may capture in the same cycle.
  - Multiple entries may capture in the same cycle.
- Ready and select:
  - An entry is ready iff valid && CB1==0 && CB2==0, using registered state.
  - vld_o = OR of ready.
  - instruction_o = the oldest ready entry by allocation order, regardless of index.
  - Issue to instruction_o is combinational from registers; there is no CDB forwarding to the output.
  - Minimum latency is 1 cycle: an operand-complete instruction accepted at edge N can issue in cycle N+1.
  - A CDB capture at edge N makes the entry issuable in cycle N+1.
- Issue: on vld_o&&rdy_o the selected entry is invalidated at the next edge. Age order of the remaining entries is preserved.
- Holding: while vld_o=1 and rdy_o=0, the selection may change only if an older entry becomes ready. Issued data must match the entry at the cycle of handshake.
- Simultaneous accept and issue are legal. The freed entry is reusable from the following cycle.
- Full: rdy_i=0 and vld_i is ignored. Empty: vld_o=0.
- Age tracking: DEPTH x DEPTH age matrix or equivalent. On allocation, the new entry is older-than none. On free, its row and column are cleared. There is no wrap-around hazard.
- CDB values for tags matching no busy operand are ignored.

Optional Feature:
- Macro: RS_CDB_BYPASS_EN.
- When defined: the incoming instruction_i is also compared against the same-cycle CDB broadcast. A matching busy operand is written already resolved (data=cdb_data_i, CB=0). This avoids a missed wakeup when the producer broadcasts in the dispatch cycle.
- When undefined: instruction_i is stored exactly as presented, and upstream must guarantee no same-cycle broadcast for incoming tags.

Test Plan:
- Reset, then dispatch {CB1=0,val1=5,CB2=0,val2=7,ROB_dest=2} with rdy_o=1 -> vld_o=1 next cycle with val1=5, val2=7; vld_o=0 the cycle after.
- Dispatch A {CB1=1,val1=tag 3}, then B ready -> B issues first. Broadcast tag 3 with data 0xDEADBEEF -> A issues next cycle with val1=0xDEADBEEF, CB1=0.
- Fill DEPTH=4 entries all waiting on tag 1, with rdy_o=1:
  - rdy_i=0 and an extra vld_i is not accepted.
  - Broadcast tag 1 -> all four become ready.
  - They issue in dispatch order over 4 cycles.
  - rdy_i=1 after the first issue.
- Entry waiting on both operands (tags 4, 5): broadcast 4, then 5 -> issues only after the second broadcast, with both values correct. A broadcast of tag 6 has no effect.
- rdy_o=0 with 2 ready entries for 3 cycles:
  - vld_o stays 1 and instruction_o is stable on the oldest.
  - flush in cycle 3 -> vld_o=0 and rdy_i=1 in cycle 4, and no entry is issued afterward.
- Bypass: with RS_CDB_BYPASS_EN, dispatch {CB1=1,val1=tag 7} in the same cycle as CDB tag 7 with data 0x10 -> issues next cycle with val1=0x10. Without the macro, the entry remains waiting.

Source files
------------

// File: rtl/reservation_station.sv
// Reservation station: buffers dispatched instructions, wakes operands from the CDB and
// issues the oldest ready entry. Define RS_CDB_BYPASS_EN to resolve operands on dispatch.
package rs_pkg;
    localparam int unsigned ROB_IDX_LEN = 4;

    typedef struct packed {
        logic [ROB_IDX_LEN-1:0] rob_dest;
        logic                   cb1;
        logic [31:0]            val1;
        logic                   cb2;
        logic [31:0]            val2;
    } instruction_element_t;
endpackage

module reservation_station
    import rs_pkg::*;
#(
    parameter int unsigned WIDTH = $bits(instruction_element_t),
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   vld_i,
    output logic                   rdy_i,
    input  logic [WIDTH-1:0]       instruction_i,
    input  logic                   cdb_vld_i,
    input  logic [ROB_IDX_LEN-1:0] cdb_tag_i,
    input  logic [31:0]            cdb_data_i,
    output logic                   vld_o,
    input  logic                   rdy_o,
    output logic [WIDTH-1:0]       instruction_o
);

    instruction_element_t entry_q [DEPTH];
    instruction_element_t entry_d [DEPTH];
    logic [DEPTH-1:0]     valid_q, valid_d;
    // older_q[i][j] set means entry i was allocated before entry j
    logic [DEPTH-1:0]     older_q [DEPTH];
    logic [DEPTH-1:0]     older_d [DEPTH];

    logic [DEPTH-1:0]     ready, sel, alloc, free;
    instruction_element_t in_elem, in_fix, out_elem;
    logic                 accept, issue, found;

    assign in_elem = instruction_element_t'(instruction_i);

    always_comb begin
        ready = '0;
        sel   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = valid_q[i] & ~entry_q[i].cb1 & ~entry_q[i].cb2;
        end
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && older_q[j][i]) sel[i] = 1'b0;
            end
        end
    end

    always_comb begin
        out_elem = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) out_elem = entry_q[i];
        end
    end

    assign instruction_o = WIDTH'(out_elem);
    assign rdy_i         = ~rst & ~flush & ~(&valid_q);
    assign vld_o         = ~rst & ~flush & (|ready);
    assign accept        = vld_i & rdy_i;
    assign issue         = vld_o & rdy_o;
    assign free          = issue ? sel : '0;

    always_comb begin
        alloc = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && !valid_q[i] && !found) begin
                alloc[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        in_fix = in_elem;
`ifdef RS_CDB_BYPASS_EN
        if (cdb_vld_i && in_elem.cb1 && in_elem.val1[ROB_IDX_LEN-1:0] == cdb_tag_i) begin
            in_fix.val1 = cdb_data_i;
            in_fix.cb1  = 1'b0;
        end
        if (cdb_vld_i && in_elem.cb2 && in_elem.val2[ROB_IDX_LEN-1:0] == cdb_tag_i) begin
            in_fix.val2 = cdb_data_i;
            in_fix.cb2  = 1'b0;
        end
`endif
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (alloc[i]) begin
                entry_d[i] = in_fix;
            end else if (valid_q[i] && cdb_vld_i) begin
                if (entry_q[i].cb1 && entry_q[i].val1[ROB_IDX_LEN-1:0] == cdb_tag_i) begin
                    entry_d[i].val1 = cdb_data_i;
                    entry_d[i].cb1  = 1'b0;
                end
                if (entry_q[i].cb2 && entry_q[i].val2[ROB_IDX_LEN-1:0] == cdb_tag_i) begin
                    entry_d[i].val2 = cdb_data_i;
                    entry_d[i].cb2  = 1'b0;
                end
            end
        end
    end

    // A new entry is younger than every surviving entry; freed rows/columns clear.
    always_comb begin
        valid_d = (valid_q & ~free) | alloc;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (i == j) begin
                    older_d[i][j] = 1'b0;
                end else if (alloc[j]) begin
                    older_d[i][j] = valid_q[i] & ~free[i];
                end else if (alloc[i]) begin
                    older_d[i][j] = 1'b0;
                end else begin
                    older_d[i][j] = older_q[i][j] & ~free[i] & ~free[j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) older_q[i] <= older_d[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed, table-driven bench for reservation_station; expected values are hand-computed.
module tb_reservation_station;
    import rs_pkg::*;

    localparam int unsigned WIDTH = $bits(instruction_element_t);

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   flush = 1'b0;
    logic                   vld_i = 1'b0;
    logic                   rdy_i;
    logic [WIDTH-1:0]       instruction_i = '0;
    logic                   cdb_vld_i = 1'b0;
    logic [ROB_IDX_LEN-1:0] cdb_tag_i = '0;
    logic [31:0]            cdb_data_i = '0;
    logic                   vld_o;
    logic                   rdy_o = 1'b0;
    logic [WIDTH-1:0]       instruction_o;

    always #5 clk = ~clk;

    reservation_station #(.WIDTH(WIDTH), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .vld_i        (vld_i),
        .rdy_i        (rdy_i),
        .instruction_i(instruction_i),
        .cdb_vld_i    (cdb_vld_i),
        .cdb_tag_i    (cdb_tag_i),
        .cdb_data_i   (cdb_data_i),
        .vld_o        (vld_o),
        .rdy_o        (rdy_o),
        .instruction_o(instruction_o)
    );

    typedef struct {
        logic                   r, f, v;
        instruction_element_t   ins;
        logic                   cv;
        logic [ROB_IDX_LEN-1:0] tag;
        logic [31:0]            data;
        logic                   ro;
        logic                   e_rdy, e_vld, e_chk;
        logic [31:0]            e_v1, e_v2;
        logic [ROB_IDX_LEN-1:0] e_dest;
    } vec_t;

    int passes = 0;
    int total  = 0;

    function automatic vec_t mk(input logic r, input logic f, input logic v, input logic cb1,
                                input logic [31:0] v1, input logic cb2, input logic [31:0] v2,
                                input logic [3:0] dest, input logic cv, input logic [3:0] tag,
                                input logic [31:0] data, input logic ro, input logic e_rdy,
                                input logic e_vld, input logic e_chk, input logic [31:0] e_v1,
                                input logic [31:0] e_v2, input logic [3:0] e_dest);
        vec_t x;
        x.r = r; x.f = f; x.v = v;
        x.ins.rob_dest = dest; x.ins.cb1 = cb1; x.ins.val1 = v1;
        x.ins.cb2 = cb2; x.ins.val2 = v2;
        x.cv = cv; x.tag = tag; x.data = data; x.ro = ro;
        x.e_rdy = e_rdy; x.e_vld = e_vld; x.e_chk = e_chk;
        x.e_v1 = e_v1; x.e_v2 = e_v2; x.e_dest = e_dest;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic apply(input vec_t x, input string lbl);
        instruction_element_t o;
        @(negedge clk);
        rst = x.r; flush = x.f; vld_i = x.v; instruction_i = WIDTH'(x.ins);
        cdb_vld_i = x.cv; cdb_tag_i = x.tag; cdb_data_i = x.data; rdy_o = x.ro;
        #1;
        o = instruction_element_t'(instruction_o);
        check({lbl, " rdy_i"}, 32'(rdy_i), 32'(x.e_rdy));
        check({lbl, " vld_o"}, 32'(vld_o), 32'(x.e_vld));
        if (x.e_chk) begin
            check({lbl, " val1"}, o.val1, x.e_v1);
            check({lbl, " val2"}, o.val2, x.e_v2);
            check({lbl, " rob_dest"}, 32'(o.rob_dest), 32'(x.e_dest));
            check({lbl, " cb"}, 32'({o.cb1, o.cb2}), 32'd0);
        end
    endtask

    vec_t vecs[29];

    initial begin
        //              r f v cb1 v1 cb2 v2 dst cv tag data ro  rdy vld chk ev1 ev2 edst
        vecs[0]  = mk(1,0,0, 0,0,0,0,0, 0,0,0, 1, 0,0,0, 0,0,0);
        vecs[1]  = mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,0,0, 0,0,0);
        vecs[2]  = mk(0,0,1, 0,5,0,7,2, 0,0,0, 1, 1,0,0, 0,0,0);
        vecs[3]  = mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,1,1, 5,7,2);
        vecs[4]  = mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,0,0, 0,0,0);
        // A waits on tag 3, B ready: B goes first
        vecs[5]  = mk(0,0,1, 1,3,0,11,4, 0,0,0, 1, 1,0,0, 0,0,0);
        vecs[6]  = mk(0,0,1, 0,20,0,21,5, 0,0,0, 1, 1,0,0, 0,0,0);
        vecs[7]  = mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,1,1, 20,21,5);
        vecs[8]  = mk(0,0,0, 0,0,0,0,0, 1,3,32'hDEADBEEF, 1, 1,0,0, 0,0,0);
        vecs[9]  = mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,1,1, 32'hDEADBEEF,11,4);
        vecs[10] = mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,0,0, 0,0,0);
        // Fill all four waiting on tag 1; extra dispatch while full is dropped
        vecs[11] = mk(0,0,1, 1,1,0,100,0, 0,0,0, 1, 1,0,0, 0,0,0);
        vecs[12] = mk(0,0,1, 1,1,0,101,1, 0,0,0, 1, 1,0,0, 0,0,0);
        vecs[13] = mk(0,0,1, 1,1,0,102,2, 0,0,0, 1, 1,0,0, 0,0,0);
        vecs[14] = mk(0,0,1, 1,1,0,103,3, 0,0,0, 1, 1,0,0, 0,0,0);
        vecs[15] = mk(0,0,1, 0,99,0,99,9, 0,0,0, 1, 0,0,0, 0,0,0);
        vecs[16] = mk(0,0,0, 0,0,0,0,0, 1,1,32'h55, 1, 0,0,0, 0,0,0);
        vecs[17] = mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 0,1,1, 32'h55,100,0);
        vecs[18] = mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,1,1, 32'h55,101,1);
        vecs[19] = mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,1,1, 32'h55,102,2);
        vecs[20] = mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,1,1, 32'h55,103,3);
        vecs[21] = mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,0,0, 0,0,0);
        // Both operands busy on tags 4 and 5; tag 6 is unrelated
        vecs[22] = mk(0,0,1, 1,4,1,5,6, 0,0,0, 1, 1,0,0, 0,0,0);
        vecs[23] = mk(0,0,0, 0,0,0,0,0, 1,6,32'h66, 1, 1,0,0, 0,0,0);
        vecs[24] = mk(0,0,0, 0,0,0,0,0, 1,4,32'h44, 1, 1,0,0, 0,0,0);
        vecs[25] = mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,0,0, 0,0,0);
        vecs[26] = mk(0,0,0, 0,0,0,0,0, 1,5,32'h45, 1, 1,0,0, 0,0,0);
        vecs[27] = mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,1,1, 32'h44,32'h45,6);
        vecs[28] = mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,0,0, 0,0,0);

        for (int i = 0; i < 29; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Hold with age differing from index, then flush
        apply(mk(0,0,1, 1,8,0,32'h30,10, 0,0,0, 0, 1,0,0, 0,0,0), "hold_x");
        apply(mk(0,0,1, 0,32'h31,0,32'h32,1, 0,0,0, 0, 1,0,0, 0,0,0), "hold_y");
        apply(mk(0,0,1, 0,32'h33,0,32'h34,2, 0,0,0, 1, 1,1,1, 32'h31,32'h32,1), "issue_y");
        apply(mk(0,0,1, 0,32'h35,0,32'h36,3, 0,0,0, 0, 1,1,1, 32'h33,32'h34,2), "hold1");
        apply(mk(0,0,0, 0,0,0,0,0, 0,0,0, 0, 1,1,1, 32'h33,32'h34,2), "hold2");
        apply(mk(0,0,0, 0,0,0,0,0, 0,0,0, 0, 1,1,1, 32'h33,32'h34,2), "hold3");
        apply(mk(0,1,1, 0,1,0,1,1, 0,0,0, 1, 0,0,0, 0,0,0), "flush");
        apply(mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,0,0, 0,0,0), "post_flush");
        apply(mk(0,0,0, 0,0,0,0,0, 1,8,32'h88, 1, 1,0,0, 0,0,0), "post_flush_cdb");
        apply(mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,0,0, 0,0,0), "post_flush_idle");

        // Dispatch in the same cycle as its producer's broadcast
        apply(mk(0,0,1, 1,7,0,32'h20,7, 1,7,32'h10, 1, 1,0,0, 0,0,0), "byp_disp");
`ifdef RS_CDB_BYPASS_EN
        apply(mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,1,1, 32'h10,32'h20,7), "byp_issue");
`else
        apply(mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,0,0, 0,0,0), "byp_wait");
`endif
        apply(mk(0,0,0, 0,0,0,0,0, 0,0,0, 1, 1,0,0, 0,0,0), "byp_after");
        apply(mk(0,1,0, 0,0,0,0,0, 0,0,0, 1, 0,0,0, 0,0,0), "byp_flush");

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
